// File: rtl/em604_div_arbiter.sv
// Round-robin arbiter/sequencer sharing one sequential divider (loadA/loadB/ini/fim
// handshake) between two requesters, with local divide-by-zero and a WAIT watchdog.
module em604_div_arbiter #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 31
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic             done0,
    output logic             done1,
    output logic             err0,
    output logic             err1,
    output logic [WIDTH-1:0] q0,
    output logic [WIDTH-1:0] r0,
    output logic [WIDTH-1:0] q1,
    output logic [WIDTH-1:0] r1,
    output logic             busy,
    output logic [WIDTH-1:0] div_A,
    output logic [WIDTH-1:0] div_B,
    output logic             div_loadA,
    output logic             div_loadB,
    output logic             div_ini,
    output logic             div_rst,
    input  logic [WIDTH-1:0] div_Q,
    input  logic [WIDTH-1:0] div_R,
    input  logic             div_fim
);

    localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_A,
        LOAD_B,
        START,
        WAIT,
        RESP
    } state_t;

    state_t           state;
    state_t           next_state;

    logic             last_grant;
    logic             owner;
    logic             arm0;
    logic             arm1;
    logic             abort;
    logic [WD_W-1:0]  wdog;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;

    logic             elig0;
    logic             elig1;
    logic             grant;
    logic             grant_idx;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic             to_resp;
    logic             resp_idx;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] res_r;
    logic             res_err;
    logic             timed_out;

    // A zero divisor saturates the quotient to all-ones.
    function automatic logic [WIDTH-1:0] zero_div_quotient();
        zero_div_quotient = '1;
    endfunction

    assign elig0 = req0 & arm0;
    assign elig1 = req1 & arm1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        grant      = 1'b0;
        grant_idx  = owner;
        sel_a      = '0;
        sel_b      = '0;
        to_resp    = 1'b0;
        resp_idx   = owner;
        res_q      = '0;
        res_r      = '0;
        res_err    = 1'b0;
        timed_out  = 1'b0;
        div_loadA  = 1'b0;
        div_loadB  = 1'b0;
        div_ini    = 1'b0;
        case (state)
            IDLE: begin
                if (elig0 | elig1) begin
                    grant     = 1'b1;
                    grant_idx = (elig0 & elig1) ? ~last_grant : elig1;
                    sel_a     = grant_idx ? a1 : a0;
                    sel_b     = grant_idx ? b1 : b0;
                    if (sel_b == '0) begin
                        next_state = RESP;
                        to_resp    = 1'b1;
                        resp_idx   = grant_idx;
                        res_q      = zero_div_quotient();
                        res_r      = sel_a;
                        res_err    = 1'b1;
                    end else begin
                        next_state = LOAD_A;
                    end
                end
            end
            LOAD_A: begin
                div_loadA  = 1'b1;
                next_state = LOAD_B;
            end
            LOAD_B: begin
                div_loadB  = 1'b1;
                next_state = START;
            end
            START: begin
                div_ini    = 1'b1;
                next_state = WAIT;
            end
            WAIT: begin
                // Completion wins over the watchdog on its last cycle.
                if (div_fim) begin
                    next_state = RESP;
                    to_resp    = 1'b1;
                    res_q      = div_Q;
                    res_r      = div_R;
                end else if (wdog == WD_LAST) begin
                    next_state = RESP;
                    to_resp    = 1'b1;
                    res_err    = 1'b1;
                    timed_out  = 1'b1;
                end
            end
            RESP: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
            owner      <= 1'b0;
            arm0       <= 1'b1;
            arm1       <= 1'b1;
            wdog       <= '0;
            abort      <= 1'b0;
            done0      <= 1'b0;
            done1      <= 1'b0;
            err0       <= 1'b0;
            err1       <= 1'b0;
            q0         <= '0;
            r0         <= '0;
            q1         <= '0;
            r1         <= '0;
        end else begin
            if (grant) begin
                last_grant <= grant_idx;
                owner      <= grant_idx;
            end
            wdog  <= (state == WAIT) ? wdog + WD_W'(1) : '0;
            abort <= timed_out;
            done0 <= to_resp & ~resp_idx;
            done1 <= to_resp & resp_idx;
            if (to_resp && !resp_idx) begin
                q0   <= res_q;
                r0   <= res_r;
                err0 <= res_err;
            end
            if (to_resp && resp_idx) begin
                q1   <= res_q;
                r1   <= res_r;
                err1 <= res_err;
            end
            // A port re-arms only once its request has been seen low after done.
            if (done0) begin
                arm0 <= 1'b0;
            end else if (!req0) begin
                arm0 <= 1'b1;
            end
            if (done1) begin
                arm1 <= 1'b0;
            end else if (!req1) begin
                arm1 <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (grant) begin
            op_a <= sel_a;
            op_b <= sel_b;
        end
    end

    assign busy    = (state != IDLE);
    assign div_A   = (state == LOAD_A || state == LOAD_B || state == START || state == WAIT) ? op_a : '0;
    assign div_B   = (state == LOAD_B || state == START || state == WAIT) ? op_b : '0;
    assign div_rst = rst | abort;

endmodule

// File: tb/tb_em604_div_arbiter.sv
// Bench for em604_div_arbiter: directed scenarios plus random traffic, checked
// against a behavioural divider and arbitration model.
module tb_em604_div_arbiter;

    localparam int W       = 8;
    localparam int TIMEOUT = 31;

    logic         clk;
    logic         rst;
    logic         req0, req1;
    logic [W-1:0] a0, b0, a1, b1;
    logic         done0, done1, err0, err1;
    logic [W-1:0] q0, r0, q1, r1;
    logic         busy;
    logic [W-1:0] div_A, div_B;
    logic         div_loadA, div_loadB, div_ini, div_rst;
    logic [W-1:0] div_Q, div_R;
    logic         div_fim;

    em604_div_arbiter #(.WIDTH(W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .done0(done0), .done1(done1), .err0(err0), .err1(err1),
        .q0(q0), .r0(r0), .q1(q1), .r1(r1), .busy(busy),
        .div_A(div_A), .div_B(div_B),
        .div_loadA(div_loadA), .div_loadB(div_loadB), .div_ini(div_ini), .div_rst(div_rst),
        .div_Q(div_Q), .div_R(div_R), .div_fim(div_fim)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Divider model: fim rises div_dly cycles after the edge that samples ini (0 = never).
    int           div_dly;
    int           dcnt;
    logic         dactive;
    logic [W-1:0] ra, rb;

    always @(posedge clk) begin
        if (div_rst) begin
            dactive <= 1'b0;
            dcnt    <= 0;
        end else begin
            if (div_loadA) ra <= div_A;
            if (div_loadB) rb <= div_B;
            if (div_ini) begin
                dactive <= 1'b1;
                dcnt    <= 0;
            end else if (dactive && dcnt < 1000) begin
                dcnt <= dcnt + 1;
            end
        end
    end

    assign div_fim = dactive && (div_dly != 0) && (dcnt >= div_dly);
    assign div_Q   = (rb == 0) ? '0 : W'(ra / rb);
    assign div_R   = (rb == 0) ? '0 : W'(ra % rb);

    int cyc, n_a, n_b, n_i, n_d0, n_d1, c_a, c_b, c_i;
    initial begin
        cyc = 0; n_a = 0; n_b = 0; n_i = 0; n_d0 = 0; n_d1 = 0; c_a = 0; c_b = 0; c_i = 0;
    end
    always @(posedge clk) cyc++;
    always @(negedge clk) begin
        if (div_loadA) begin n_a++; c_a = cyc; end
        if (div_loadB) begin n_b++; c_b = cyc; end
        if (div_ini)   begin n_i++; c_i = cyc; end
        if (done0) n_d0++;
        if (done1) n_d1++;
    end

    int           n_checks = 0;
    int           n_fail   = 0;
    int           mdl_last;
    logic [W-1:0] mq [2];
    logic [W-1:0] mr [2];
    logic         me [2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int p, input int limit, output int lat);
        lat = 0;
        forever begin
            tick();
            lat++;
            if ((p == 0 && done0) || (p == 1 && done1)) break;
            if (lat >= limit) begin
                check($sformatf("done%0d_timeout", p), 32'(lat), 32'(limit + 1));
                break;
            end
        end
    endtask

    function automatic int exp_lat(input logic [W-1:0] y, input int dly);
        if (y == 0) return 1;
        if (dly >= 1 && dly < TIMEOUT) return 5 + dly;
        return 4 + TIMEOUT;
    endfunction

    task automatic expect_res(input logic [W-1:0] x, input logic [W-1:0] y, input int dly,
                              output logic [W-1:0] eq, output logic [W-1:0] er,
                              output logic ee, output logic to);
        to = 1'b0;
        if (y == 0) begin
            eq = '1; er = x; ee = 1'b1;
        end else if (dly >= 1 && dly < TIMEOUT) begin
            eq = x / y; er = x % y; ee = 1'b0;
        end else begin
            eq = '0; er = '0; ee = 1'b1; to = 1'b1;
        end
    endtask

    // Waits for port p to complete one transaction and checks it against the model.
    task automatic collect(input int p, input logic [W-1:0] x, input logic [W-1:0] y,
                           input int dly, input int extra);
        int           lat, sa, sb, si, o;
        logic [W-1:0] eq, er;
        logic         ee, to;
        sa = n_a; sb = n_b; si = n_i; o = 1 - p;
        expect_res(x, y, dly, eq, er, ee, to);
        wait_done(p, 100, lat);
        check($sformatf("latency%0d", p), 32'(lat), 32'(extra + exp_lat(y, dly)));
        check($sformatf("q%0d", p), 32'(p ? q1 : q0), 32'(eq));
        check($sformatf("r%0d", p), 32'(p ? r1 : r0), 32'(er));
        check($sformatf("err%0d", p), 32'(p ? err1 : err0), 32'(ee));
        check("busy_resp", 32'(busy), 32'(1));
        check("div_rst_resp", 32'(div_rst), 32'(to));
        check("loadA_count", 32'(n_a - sa), 32'((y == 0) ? 0 : 1));
        check("loadB_count", 32'(n_b - sb), 32'((y == 0) ? 0 : 1));
        check("ini_count", 32'(n_i - si), 32'((y == 0) ? 0 : 1));
        check($sformatf("done%0d_quiet", o), 32'(o ? done1 : done0), 32'(0));
        check($sformatf("q%0d_held", o), 32'(o ? q1 : q0), 32'(mq[o]));
        check($sformatf("r%0d_held", o), 32'(o ? r1 : r0), 32'(mr[o]));
        mq[p] = eq; mr[p] = er; me[p] = ee;
        mdl_last = p;
    endtask

    task automatic serve(input logic u0, input logic u1,
                         input logic [W-1:0] x0, input logic [W-1:0] y0,
                         input logic [W-1:0] x1, input logic [W-1:0] y1, input int dly);
        int first;
        div_dly = dly;
        a0 = x0; b0 = y0; a1 = x1; b1 = y1;
        req0 = u0; req1 = u1;
        first = (u0 && u1) ? 1 - mdl_last : (u1 ? 1 : 0);
        collect(first, first ? x1 : x0, first ? y1 : y0, dly, 0);
        if (first == 0) req0 = 1'b0; else req1 = 1'b0;
        if (u0 && u1) begin
            collect(1 - first, first ? x0 : x1, first ? y0 : y1, dly, 1);
            if (first == 0) req1 = 1'b0; else req0 = 1'b0;
        end
        tick();
        tick();
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation exceeded its time budget");
        $fatal(1, "bench time budget exhausted");
    end

    initial begin
        int           mode, dly, sd0;
        logic [W-1:0] x0v, y0v, x1v, y1v;

        rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0; div_dly = 0;
        mdl_last = 1;
        for (int k = 0; k < 2; k++) begin mq[k] = '0; mr[k] = '0; me[k] = 1'b0; end
        repeat (3) tick();

        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done0", 32'(done0), 32'(0));
        check("rst_done1", 32'(done1), 32'(0));
        check("rst_err0", 32'(err0), 32'(0));
        check("rst_q0", 32'(q0), 32'(0));
        check("rst_r1", 32'(r1), 32'(0));
        check("rst_strobes", 32'({div_loadA, div_loadB, div_ini}), 32'(0));
        check("rst_div_rst", 32'(div_rst), 32'(1));
        rst = 1'b0;
        tick();
        check("div_rst_release", 32'(div_rst), 32'(0));

        // Simultaneous requests right after reset: port 0 first, then port 1.
        serve(1'b1, 1'b1, 8'd9, 8'd2, 8'd200, 8'd10, 5);

        // Port 0 alone, D=16; operand changes after the grant must be ignored.
        div_dly = 16; a0 = 8'd100; b0 = 8'd7; req0 = 1'b1;
        tick();
        check("busy_after_grant", 32'(busy), 32'(1));
        a0 = 8'h33; b0 = 8'h00;
        collect(0, 8'd100, 8'd7, 16, -1);
        check("loadB_after_loadA", 32'(c_b - c_a), 32'(1));
        check("ini_after_loadA", 32'(c_i - c_a), 32'(2));
        req0 = 1'b0;
        tick();
        tick();

        // Last grant was port 0, so this tie serves port 1 first.
        serve(1'b1, 1'b1, 8'd17, 8'd4, 8'd99, 8'd9, 3);
        serve(1'b0, 1'b1, 8'd0, 8'd1, 8'd55, 8'd0, 5);
        serve(1'b1, 1'b0, 8'd100, 8'd7, 8'd0, 8'd1, 0);

        // Held request after done must not be re-granted until it drops.
        div_dly = 4; a0 = 8'd60; b0 = 8'd7; req0 = 1'b1;
        collect(0, 8'd60, 8'd7, 4, 0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("held_busy", 32'(busy), 32'(0));
            check("held_done0", 32'(done0), 32'(0));
        end
        req0 = 1'b0;
        tick();
        serve(1'b1, 1'b0, 8'd60, 8'd8, 8'd0, 8'd1, 4);

        // Reset in the middle of WAIT aborts silently and restores last_grant.
        div_dly = 0; a0 = 8'd50; b0 = 8'd5; req0 = 1'b1;
        repeat (8) tick();
        check("busy_in_wait", 32'(busy), 32'(1));
        sd0 = n_d0;
        req0 = 1'b0; rst = 1'b1;
        tick();
        check("midrst_busy", 32'(busy), 32'(0));
        check("midrst_div_rst", 32'(div_rst), 32'(1));
        check("midrst_q0", 32'(q0), 32'(0));
        rst = 1'b0;
        mdl_last = 1;
        for (int k = 0; k < 2; k++) begin mq[k] = '0; mr[k] = '0; me[k] = 1'b0; end
        tick();
        check("midrst_no_done", 32'(n_d0 - sd0), 32'(0));
        serve(1'b1, 1'b1, 8'd30, 8'd4, 8'd31, 8'd5, 6);

        for (int it = 0; it < 16; it++) begin
            mode = int'($urandom_range(0, 2));
            x0v = W'($urandom_range(0, 255));
            x1v = W'($urandom_range(0, 255));
            y0v = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom_range(1, 255));
            y1v = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom_range(1, 255));
            dly = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, TIMEOUT - 1));
            serve(mode != 1, mode != 0, x0v, y0v, x1v, y1v, dly);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
